// File: rtl/addsub_pkg.sv
// Shared types and constants for the addsub issue/result stage.
// Saturation constants are used only when ADDSUB_SAT_EN is defined.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_ACC    = 2'd2,
    OP_ACCSUB = 2'd3
  } op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/addsub.sv
// Combinational add/subtract: sum = a + b when sub=0, a - b (two's complement) when sub=1.
module addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + (b ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/addsub_acc_stage.sv
// Registered issue/result stage around addsub: operand select, N/Z/C/V flags, accumulator, output FIFO.
// Optional saturation of overflowing results is enabled by defining ADDSUB_SAT_EN.
module addsub_acc_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic [WIDTH-1:0] acc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if (WIDTH != 32) begin : g_bad_width
      $error("addsub_acc_stage: WIDTH must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("addsub_acc_stage: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  op_t              op;
  logic             use_acc;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic             bx_msb;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] result;
  flags_t           res_flags;
  logic             carry;
  logic             ovf;

  logic [WIDTH-1:0] acc_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [WIDTH-1:0] sum_mem   [DEPTH];
  flags_t           flags_mem [DEPTH];

  logic push;
  logic pop;

  assign op      = op_t'(in_op);
  assign use_acc = (op == OP_ACC) || (op == OP_ACCSUB);
  assign sub     = (op == OP_SUB) || (op == OP_ACCSUB);
  assign op_a    = use_acc ? acc_reg : in_a;
  assign bx_msb  = in_b[WIDTH-1] ^ sub;

  addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (op_a),
    .b   (in_b),
    .sub (sub),
    .sum (raw_sum)
  );

  // Carry out of the MSB; for subtraction C=1 means no borrow.
  assign carry = (op_a[WIDTH-1] & bx_msb) | ((op_a[WIDTH-1] ^ bx_msb) & ~raw_sum[WIDTH-1]);
  assign ovf   = (op_a[WIDTH-1] == bx_msb) && (raw_sum[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
`ifdef ADDSUB_SAT_EN
    result = ovf ? (op_a[WIDTH-1] ? SAT_NEG : SAT_POS) : raw_sum;
`else
    result = raw_sum;
`endif
    res_flags.n = result[WIDTH-1];
    res_flags.z = (result == '0);
    res_flags.c = carry;
    res_flags.v = ovf;
  end

  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      acc_reg    <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (use_acc) begin
          acc_reg <= result;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count_reg covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr_reg]   <= result;
      flags_mem[wr_ptr_reg] <= res_flags;
    end
  end

  assign out_sum   = out_valid ? sum_mem[rd_ptr_reg] : '0;
  assign out_flags = out_valid ? flags_mem[rd_ptr_reg] : 4'b0000;
  assign acc       = acc_reg;

endmodule

// File: tb/tb_addsub_acc_stage.sv
// Self-checking bench for addsub_acc_stage: directed vector table, multi-cycle sequences, random handshake run.
// Expected values follow ADDSUB_SAT_EN when it is defined for the build.
module tb_addsub_acc_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic [3:0]  out_flags;
  logic [31:0] acc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_acc_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .acc       (acc)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: 33-bit arithmetic, carry from bit 32, overflow from operand/result signs.
  function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] accv);
    logic [32:0] t;
    logic [31:0] x;
    logic [31:0] s;
    logic        c;
    logic        v;
    x = op[1] ? accv : a;
    if (op[0]) t = {1'b0, x} + {1'b0, ~b} + 33'd1;
    else       t = {1'b0, x} + {1'b0, b};
    s = t[31:0];
    c = t[32];
    if (op[0]) v = (x[31] != b[31]) && (s[31] != x[31]);
    else       v = (x[31] == b[31]) && (s[31] != x[31]);
`ifdef ADDSUB_SAT_EN
    if (v) s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {s[31], (s == 32'd0), c, v, s};
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    logic [35:0] q[$];
    logic [35:0] exp_v;
    logic [31:0] model_acc;
    int          issued;
    int          cycles;
    int          popped;
    bit          accepted;

    // {op, a, b, expected sum, expected {N,Z,C,V}}
    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 4'b0110};
    vecs[1] = '{2'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, 4'b1000};
    vecs[2] = '{2'd1, 32'd7,         32'd5,         32'h0000_0002, 4'b0010};
`ifdef ADDSUB_SAT_EN
    vecs[3] = '{2'd0, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 4'b0001};
    vecs[4] = '{2'd1, 32'h8000_0000, 32'd1,         32'h8000_0000, 4'b1011};
    vecs[5] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b1011};
`else
    vecs[3] = '{2'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001};
    vecs[4] = '{2'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011};
    vecs[5] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};
`endif
    vecs[6] = '{2'd1, 32'd0,         32'd0,         32'h0000_0000, 4'b0110};
    vecs[7] = '{2'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000};

    // Reset state, checked before any clock edge
    #2;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready",  {63'd0, in_ready},  64'd1);
    check("reset_out_sum",   {32'd0, out_sum},   64'd0);
    check("reset_out_flags", {60'd0, out_flags}, 64'd0);
    check("reset_acc",       {32'd0, acc},       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, one op at a time with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      $display("[TB] vec %0d op=%0d a=%h b=%h -> sum=%h flags=%b", i, vecs[i].op, vecs[i].a, vecs[i].b,
               out_sum, out_flags);
      check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("vec%0d_sum", i),   {32'd0, out_sum},   {32'd0, vecs[i].sum});
      check($sformatf("vec%0d_flags", i), {60'd0, out_flags}, {60'd0, vecs[i].flags});
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
    end
    #1;
    check("vec_acc_untouched", {32'd0, acc}, 64'd0);

    // Back-to-back accumulate chain, in_a must be ignored
    do_reset();
    drive(2'd2, 32'hDEAD, 32'd10);
    @(posedge clk); #1;
    $display("[TB] ACC b=10 -> sum=%h acc=%h", out_sum, acc);
    check("acc1_sum", {32'd0, out_sum}, 64'd10);
    check("acc1_acc", {32'd0, acc},     64'd10);
    @(negedge clk);
    drive(2'd2, 32'hDEAD, 32'd5);
    @(posedge clk); #1;
    $display("[TB] ACC b=5 -> sum=%h acc=%h", out_sum, acc);
    check("acc2_sum", {32'd0, out_sum}, 64'd15);
    check("acc2_acc", {32'd0, acc},     64'd15);
    @(negedge clk);
    drive(2'd3, 32'hDEAD, 32'd20);
    @(posedge clk); #1;
    $display("[TB] ACCSUB b=20 -> sum=%h flags=%b acc=%h", out_sum, out_flags, acc);
    check("acc3_sum",   {32'd0, out_sum},   64'h0000_0000_FFFF_FFFB);
    check("acc3_flags", {60'd0, out_flags}, 64'h8);
    check("acc3_acc",   {32'd0, acc},       64'h0000_0000_FFFF_FFFB);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("acc_drain_valid", {63'd0, out_valid}, 64'd0);
    check("acc_drain_sum",   {32'd0, out_sum},   64'd0);
    check("acc_drain_flags", {60'd0, out_flags}, 64'd0);

    // Backpressure: FIFO fills after two accepts, the third op is held until space frees
    do_reset();
    out_ready = 1'b0;
    check("bp_ready_empty", {63'd0, in_ready}, 64'd1);
    drive(2'd0, 32'd1, 32'd1);
    @(posedge clk); #1;
    check("bp_first_sum", {32'd0, out_sum}, 64'd2);
    @(negedge clk);
    drive(2'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    check("bp_full_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    drive(2'd1, 32'd10, 32'd1);
    @(posedge clk); #1;
    check("bp_held_ready", {63'd0, in_ready}, 64'd0);
    check("bp_held_head",  {32'd0, out_sum},  64'd2);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    $display("[TB] bp pop -> sum=%h in_ready=%b", out_sum, in_ready);
    check("bp_pop1_sum",   {32'd0, out_sum},  64'd7);
    check("bp_pop1_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    $display("[TB] bp push+pop -> sum=%h", out_sum);
    check("bp_pop2_sum", {32'd0, out_sum}, 64'd9);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_empty_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset with two results buffered and acc=15
    do_reset();
    out_ready = 1'b0;
    drive(2'd2, 32'd0, 32'd10);
    @(negedge clk);
    drive(2'd2, 32'd0, 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_pre_acc",   {32'd0, acc},       64'd15);
    check("rst_pre_head",  {32'd0, out_sum},   64'd10);
    check("rst_pre_ready", {63'd0, in_ready},  64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset -> out_valid=%b out_sum=%h acc=%h", out_valid, out_sum, acc);
    check("rst_async_valid", {63'd0, out_valid}, 64'd0);
    check("rst_async_sum",   {32'd0, out_sum},   64'd0);
    check("rst_async_acc",   {32'd0, acc},       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_post_ready", {63'd0, in_ready},  64'd1);
    check("rst_post_valid", {63'd0, out_valid}, 64'd0);

    // Random valid/ready traffic against the scoreboard
    do_reset();
    model_acc = '0;
    issued    = 0;
    popped    = 0;
    cycles    = 0;
    while ((issued < 1000 || q.size() != 0) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && issued < 1000 && $urandom_range(0, 3) != 0) begin
        drive(2'($urandom_range(0, 3)), $urandom, $urandom);
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious_pop", 64'd1, 64'd0);
        end else begin
          exp_v = q.pop_front();
          $display("[TB] rand pop %0d sum=%h flags=%b", popped, out_sum, out_flags);
          check($sformatf("rand_pop%0d", popped), {28'd0, out_flags, out_sum}, {28'd0, exp_v});
          popped++;
        end
      end
      accepted = 1'b0;
      if (in_valid && in_ready) begin
        exp_v = model(in_op, in_a, in_b, model_acc);
        q.push_back(exp_v);
        if (in_op[1]) model_acc = exp_v[31:0];
        issued++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
    end
    check("rand_complete", {32'd0, 32'(popped)}, 64'd1000);
    check("rand_acc", {32'd0, acc}, {32'd0, model_acc});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
